sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Two-requester arbiter that shares the single 32-bit SRAM controller port between
//  the instruction-cache miss path (M0) and the data-cache miss path (M1).
//  Sits between both caches' memory-side req/ACK interfaces and the SRAM controller.
//  Registers the winning command and holds it stable until the controller ACKs.
//  Includes a watchdog that releases a hung transaction and raises a sticky error.
// PARAMETERS
//  PRIORITY     0     0 = round-robin between M0/M1; 1 = fixed priority, M1 (data) wins
//  TIMEOUT_CYC  1024  max BUSY cycles waiting for i_mem_ack before forced release (>=2)
//  AW           32    address width forwarded to the controller
// PORTS
//  i_clk        in   1   system clock, all state on rising edge
//  i_rst        in   1   synchronous reset, active-low
//  i_m0_addr    in   AW  M0 (I-cache) address
//  i_m0_wdata   in   32  M0 write data
//  i_m0_rd      in   1   M0 read request, level, held until o_m0_ack
//  i_m0_wr      in   1   M0 write request, level, held until o_m0_ack
//  o_m0_rdata   out  32  M0 read data, valid in o_m0_ack cycle
//  o_m0_ack     out  1   M0 completion pulse
//  i_m1_*/o_m1_*         identical set for M1 (D-cache)
//  o_mem_addr   out  AW  registered address to the SRAM controller
//  o_mem_wdata  out  32  registered write data
//  o_mem_rd     out  1   read command, level
//  o_mem_wr     out  1   write command, level
//  i_mem_rdata  in   32  controller read data
//  i_mem_ack    in   1   controller completion pulse (one cycle)
//  o_busy       out  1   1 while state != IDLE
//  o_err        out  1   sticky: a watchdog timeout occurred; cleared only by reset
// BEHAVIOUR
//  Reset (i_rst==0 at edge): state=IDLE, o_mem_rd/wr=0, o_mem_addr/wdata=0, o_busy=0,
//   o_err=0, timeout counter=0, last_grant=M1 (so RR grants M0 first). Reset mid-BUSY
//   aborts: command lines low from the next edge, no ack issued.
//  States: IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: req_n = i_mn_rd | i_mn_wr. If any req: pick winner (PRIORITY=1: M1 if req1;
//   PRIORITY=0: the non-last_grant master if both, else the sole requester); capture
//   addr/wdata/command into o_mem_*; set grant, last_grant=grant; -> BUSY.
//   Command visible on o_mem_* the cycle after the request is sampled (1-cycle latency).
//  rd&wr both high from one master: forwarded as write only (o_mem_rd=0).
//  BUSY: o_mem_* held constant; counter increments each cycle.
//   i_mem_ack=1: o_m<grant>_ack=1 combinationally that cycle, o_m<grant>_rdata=
//   i_mem_rdata; drop o_mem_rd/wr at the edge; -> RELEASE.
//   counter==TIMEOUT_CYC-1 without ack: o_m<grant>_ack=1, rdata=0, o_err<=1, -> RELEASE.
//   Ack and timeout in the same cycle: treat as normal ack, o_err unchanged.
//  RELEASE: one cycle, all requests ignored (masters still hold level req this cycle),
//   counter cleared; -> IDLE. Minimum back-to-back spacing = 3 cycles per transaction.
//  Non-granted master: ack=0, rdata=0 always; its request waits, never dropped.
//  i_mem_ack outside BUSY: ignored, no ack forwarded.
//  Request changes by granted master while BUSY: ignored (captured copy used).
//  RR fairness: with both requesting continuously, grants strictly alternate.
// TESTING
//  1 M1 rd addr 0x100, ack 3 cyc after o_mem_rd rises, rdata 0xDEADBEEF -> o_m1_ack
//    1 cyc with 0xDEADBEEF, o_mem_rd high exactly 3 cyc, o_m0_ack stays 0.
//  2 PRIORITY=0, M0 & M1 rd same cycle after reset -> M0 granted first, M1 next;
//    both held 4 txns -> grants M0,M1,M0,M1. PRIORITY=1 -> M1 first every contest.
//  3 M0 wr 0x20/0x12345678 holding req through ack -> exactly one o_mem_wr burst,
//    RELEASE blocks a duplicate; next txn only if req still high after RELEASE.
//  4 TIMEOUT_CYC=8, M1 rd, no i_mem_ack -> o_m1_ack on 8th BUSY cyc, rdata 0, o_err=1
//    and stays 1 through later good txns until i_rst=0.
//  5 i_rst=0 for 1 cyc mid-BUSY -> next edge o_mem_rd/wr=0, o_busy=0, no ack pulse;
//    late i_mem_ack afterward ignored.
//  6 M0 rd&wr both high, wdata 0xA5A5A5A5 -> o_mem_wr=1, o_mem_rd=0, data forwarded.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two cache miss paths, the arbiter and the SRAM controller.
// slave = arbiter side, master = environment (caches + controller) side.
interface sram_port_arbiter_if #(
    parameter int unsigned AW = 32
) ();
    logic [AW-1:0] i_m0_addr;
    logic [31:0]   i_m0_wdata;
    logic          i_m0_rd;
    logic          i_m0_wr;
    logic [31:0]   o_m0_rdata;
    logic          o_m0_ack;

    logic [AW-1:0] i_m1_addr;
    logic [31:0]   i_m1_wdata;
    logic          i_m1_rd;
    logic          i_m1_wr;
    logic [31:0]   o_m1_rdata;
    logic          o_m1_ack;

    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_rd;
    logic          o_mem_wr;
    logic [31:0]   i_mem_rdata;
    logic          i_mem_ack;

    modport slave (
        input  i_m0_addr, i_m0_wdata, i_m0_rd, i_m0_wr,
        output o_m0_rdata, o_m0_ack,
        input  i_m1_addr, i_m1_wdata, i_m1_rd, i_m1_wr,
        output o_m1_rdata, o_m1_ack,
        output o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
        input  i_mem_rdata, i_mem_ack
    );

    modport master (
        output i_m0_addr, i_m0_wdata, i_m0_rd, i_m0_wr,
        input  o_m0_rdata, o_m0_ack,
        output i_m1_addr, i_m1_wdata, i_m1_rd, i_m1_wr,
        input  o_m1_rdata, o_m1_ack,
        input  o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
        output i_mem_rdata, i_mem_ack
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master (I-cache / D-cache) arbiter for the single SRAM controller port,
// with registered command, round-robin or fixed priority, and a hang watchdog.
module sram_port_arbiter #(
    parameter int unsigned PRIORITY    = 0,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned AW          = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sram_port_arbiter_if.slave  bus,
    output logic                o_busy,
    output logic                o_err
);
    localparam int unsigned    CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          last_grant;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rd;
    logic          mem_wr;

    logic req0, req1, win, timeout, done;

    always_comb begin
        req0 = bus.i_m0_rd | bus.i_m0_wr;
        req1 = bus.i_m1_rd | bus.i_m1_wr;
        if (PRIORITY != 0)
            win = req1;
        else if (req0 && req1)
            win = ~last_grant;
        else
            win = req1;
        timeout = (state == ST_BUSY) && (cnt == CNT_LAST);
        // Completion is suppressed during reset so an aborted transaction never acks.
        done    = i_rst && (state == ST_BUSY) && (bus.i_mem_ack || timeout);
    end

    assign bus.o_m0_ack    = done && !grant;
    assign bus.o_m1_ack    = done && grant;
    assign bus.o_m0_rdata  = (done && !grant && bus.i_mem_ack) ? bus.i_mem_rdata : '0;
    assign bus.o_m1_rdata  = (done && grant && bus.i_mem_ack) ? bus.i_mem_rdata : '0;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_mem_rd    = mem_rd;
    assign bus.o_mem_wr    = mem_wr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant      <= win;
                        last_grant <= win;
                        mem_addr   <= win ? bus.i_m1_addr  : bus.i_m0_addr;
                        mem_wdata  <= win ? bus.i_m1_wdata : bus.i_m0_wdata;
                        // A simultaneous rd+wr from one master is forwarded as a write.
                        mem_wr     <= win ? bus.i_m1_wr : bus.i_m0_wr;
                        mem_rd     <= win ? (bus.i_m1_rd & ~bus.i_m1_wr)
                                          : (bus.i_m0_rd & ~bus.i_m0_wr);
                        cnt        <= '0;
                        o_busy     <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (bus.i_mem_ack || timeout) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= ST_RELEASE;
                        if (!bus.i_mem_ack)
                            o_err <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    cnt    <= '0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: masters push expected responses and commands; monitors pop and
// compare on every ack and every new SRAM command.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.AW(32)) bus0 ();
    sram_port_arbiter_if #(.AW(32)) bus1 ();
    logic busy0, err0, busy1, err1;

    sram_port_arbiter #(.PRIORITY(0), .TIMEOUT_CYC(8), .AW(32)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus0), .o_busy(busy0), .o_err(err0));
    sram_port_arbiter #(.PRIORITY(1), .TIMEOUT_CYC(8), .AW(32)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .bus(bus1), .o_busy(busy1), .o_err(err1));

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } cmd_t;

    int tests = 0;
    int errors = 0;
    logic [31:0] exp_rdata_q0[$];
    logic [31:0] exp_rdata_q1[$];
    cmd_t        cmd_q0[$];
    cmd_t        cmd_q1[$];
    int          grant_log[$];
    int          burst_count = 0;
    int          cur_len = 0;
    int          last_len = 0;
    logic        prev_cmd = 1'b0;
    cmd_t        held;
    logic [31:0] sram [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          resp_en = 1'b1;
    int          fix_delay = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], 16'h5A3C} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Behavioural SRAM controller for dut0: acks 1..4 cycles into the command.
    initial begin
        bus0.i_mem_ack   = 1'b0;
        bus0.i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && (bus0.o_mem_rd || bus0.o_mem_wr)) begin
                int d;
                logic [31:0] a;
                a = bus0.o_mem_addr;
                d = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                bus0.i_mem_ack = 1'b1;
                if (bus0.o_mem_wr) begin
                    sram[a] = bus0.o_mem_wdata;
                    bus0.i_mem_rdata = '0;
                end else begin
                    bus0.i_mem_rdata = sram.exists(a) ? sram[a] : init_val(a);
                end
                @(posedge clk);
                #1;
                bus0.i_mem_ack   = 1'b0;
                bus0.i_mem_rdata = '0;
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus0.o_m0_ack && bus0.o_m1_ack) begin
                tests++; errors++;
                $display("FAIL both_ack: got m0_ack=1 m1_ack=1 expected at most one");
            end
            if (bus0.o_m0_ack) begin
                if (exp_rdata_q0.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL m0_unexpected_ack: got ack=1 expected ack=0");
                end else begin
                    check("m0_rdata", bus0.o_m0_rdata, exp_rdata_q0.pop_front());
                end
                check("m1_rdata_idle", bus0.o_m1_rdata, 32'h0);
            end
            if (bus0.o_m1_ack) begin
                if (exp_rdata_q1.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL m1_unexpected_ack: got ack=1 expected ack=0");
                end else begin
                    check("m1_rdata", bus0.o_m1_rdata, exp_rdata_q1.pop_front());
                end
                check("m0_rdata_idle", bus0.o_m0_rdata, 32'h0);
            end
        end
    end

    // Command monitor: every new SRAM command must match the owner's next request.
    initial begin
        forever begin
            cmd_t cur;
            cmd_t exp;
            logic cmd;
            int   m;
            @(negedge clk);
            cmd = bus0.o_mem_rd | bus0.o_mem_wr;
            cur = '{bus0.o_mem_addr, bus0.o_mem_wdata, bus0.o_mem_rd, bus0.o_mem_wr};
            if (cmd && !prev_cmd) begin
                m = int'(bus0.o_mem_addr[8]);
                tests++;
                if ((m == 0 && cmd_q0.size() == 0) || (m == 1 && cmd_q1.size() == 0)) begin
                    errors++;
                    $display("FAIL mem_unexpected_cmd: got %h expected no command", cur);
                end else begin
                    exp = (m == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL mem_cmd: got %h expected %h", cur, exp);
                    end
                end
                grant_log.push_back(m);
                burst_count++;
                held    = cur;
                cur_len = 1;
            end else if (cmd) begin
                cur_len++;
                if (cur !== held) begin
                    tests++; errors++;
                    $display("FAIL mem_cmd_stable: got %h expected %h", cur, held);
                end
            end else if (prev_cmd) begin
                last_len = cur_len;
            end
            prev_cmd = cmd;
        end
    end

    // Issue one transaction from master m and hold the level request until its ack.
    task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input bit tmo);
        logic [31:0] er;
        cmd_t        c;
        bit          got;
        c = '{addr, wdata, rd & ~wr, wr};
        if (tmo || wr)
            er = '0;
        else
            er = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
        if (wr && !tmo)
            ref_mem[addr] = wdata;
        if (m == 0) begin
            exp_rdata_q0.push_back(er);
            cmd_q0.push_back(c);
            bus0.i_m0_addr = addr; bus0.i_m0_wdata = wdata;
            bus0.i_m0_rd = rd;     bus0.i_m0_wr = wr;
        end else begin
            exp_rdata_q1.push_back(er);
            cmd_q1.push_back(c);
            bus0.i_m1_addr = addr; bus0.i_m1_wdata = wdata;
            bus0.i_m1_rd = rd;     bus0.i_m1_wr = wr;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? bus0.o_m0_ack : bus0.o_m1_ack;
        end
        if (!got) begin
            tests++; errors++;
            $display("FAIL m%0d_ack_wait: got no ack expected ack within 40 cycles", m);
        end
        sync();
        if (m == 0) begin
            bus0.i_m0_rd = 1'b0; bus0.i_m0_wr = 1'b0;
        end else begin
            bus0.i_m1_rd = 1'b0; bus0.i_m1_wr = 1'b0;
        end
    endtask

    task automatic rand_master(input int m, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int op;
            a  = 32'(m * 256 + 4 * int'($urandom_range(0, 15)));
            op = int'($urandom_range(0, 2));
            issue(m, a, $urandom, (op != 1), (op != 0), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_cmd1(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = bus1.o_mem_rd;
        end
        if (!seen) begin
            tests++; errors++;
            $display("FAIL %s: got no command expected o_mem_rd within 12 cycles", name);
        end
    endtask

    task automatic ack1();
        sync();
        bus1.i_mem_ack = 1'b1;
        bus1.i_mem_rdata = 32'h0000_0011;
        @(negedge clk);
    endtask

    initial begin
        int bc;
        rst_n = 1'b0;
        bus0.i_m0_addr = '0; bus0.i_m0_wdata = '0; bus0.i_m0_rd = 1'b0; bus0.i_m0_wr = 1'b0;
        bus0.i_m1_addr = '0; bus0.i_m1_wdata = '0; bus0.i_m1_rd = 1'b0; bus0.i_m1_wr = 1'b0;
        bus1.i_m0_addr = '0; bus1.i_m0_wdata = '0; bus1.i_m0_rd = 1'b0; bus1.i_m0_wr = 1'b0;
        bus1.i_m1_addr = '0; bus1.i_m1_wdata = '0; bus1.i_m1_rd = 1'b0; bus1.i_m1_wr = 1'b0;
        bus1.i_mem_ack = 1'b0; bus1.i_mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_cmd", {30'b0, bus0.o_mem_rd, bus0.o_mem_wr}, 32'h0);
        check("rst_mem_addr", bus0.o_mem_addr, 32'h0);
        check("rst_mem_wdata", bus0.o_mem_wdata, 32'h0);
        check("rst_busy", {31'b0, busy0}, 32'h0);
        check("rst_err", {31'b0, err0}, 32'h0);
        sync();
        rst_n = 1'b1;
        grant_log.delete();

        // Round-robin: both hold requests for four transactions, M0 first after reset.
        fork
            begin issue(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0); issue(0, 32'h14, 32'h0, 1'b1, 1'b0, 1'b0); end
            begin issue(1, 32'h110, 32'h0, 1'b1, 1'b0, 1'b0); issue(1, 32'h114, 32'h0, 1'b1, 1'b0, 1'b0); end
        join
        check("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("rr_grant", grant_log[i], i % 2);

        // Single M1 read with the ack in the third command cycle.
        sram[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        fix_delay = 2;
        issue(1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_rd_len", last_len, 3);
        sync();
        fix_delay = 0;

        // rd+wr together is a write; read it back.
        issue(0, 32'h40, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0);
        issue(0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);

        // A held write request yields exactly one command burst.
        bc = burst_count;
        issue(0, 32'h20, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        repeat (4) sync();
        check("t3_single_burst", burst_count - bc, 1);
        issue(0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stray controller ack while idle.
        bus0.i_mem_ack = 1'b1;
        bus0.i_mem_rdata = 32'h0BAD_0BAD;
        sync();
        bus0.i_mem_ack = 1'b0;
        bus0.i_mem_rdata = '0;
        @(negedge clk);
        check("stray_ack_busy", {31'b0, busy0}, 32'h0);
        sync();

        fork
            rand_master(0, 25);
            rand_master(1, 25);
        join

        // Watchdog: no controller ack.
        resp_en = 1'b0;
        issue(1, 32'h150, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_busy_len", last_len, 8);
        check("t4_err", {31'b0, err0}, 32'h1);
        sync();
        resp_en = 1'b1;
        issue(0, 32'h24, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(1, 32'h154, 32'h7777_0001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_err_sticky", {31'b0, err0}, 32'h1);
        sync();

        // Reset in the middle of a transaction.
        resp_en = 1'b0;
        cmd_q1.push_back('{32'h160, 32'h0, 1'b1, 1'b0});
        bus0.i_m1_addr = 32'h160; bus0.i_m1_wdata = '0; bus0.i_m1_rd = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                seen = bus0.o_mem_rd;
            end
            check("t5_cmd_seen", {31'b0, seen}, 32'h1);
        end
        sync();
        rst_n = 1'b0;
        bus0.i_m1_rd = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_mem_cmd", {30'b0, bus0.o_mem_rd, bus0.o_mem_wr}, 32'h0);
        check("t5_busy", {31'b0, busy0}, 32'h0);
        check("t5_err_cleared", {31'b0, err0}, 32'h0);
        sync();
        bus0.i_mem_ack = 1'b1;
        bus0.i_mem_rdata = 32'h1234_0000;
        sync();
        bus0.i_mem_ack = 1'b0;
        bus0.i_mem_rdata = '0;
        @(negedge clk);
        check("t5_late_ack_busy", {31'b0, busy0}, 32'h0);
        sync();
        resp_en = 1'b1;

        // Fixed priority instance: M1 wins every contest.
        bus1.i_m0_addr = 32'h30;  bus1.i_m0_rd = 1'b1;
        bus1.i_m1_addr = 32'h130; bus1.i_m1_rd = 1'b1;
        wait_cmd1("p1_wait1");
        check("p1_first_addr", bus1.o_mem_addr, 32'h130);
        ack1();
        check("p1_ack_m1", {30'b0, bus1.o_m1_ack, bus1.o_m0_ack}, 32'h2);
        check("p1_rdata_m1", bus1.o_m1_rdata, 32'h11);
        sync();
        bus1.i_mem_ack = 1'b0;
        wait_cmd1("p1_wait2");
        check("p1_second_addr", bus1.o_mem_addr, 32'h130);
        ack1();
        sync();
        bus1.i_mem_ack = 1'b0;
        bus1.i_m1_rd = 1'b0;
        wait_cmd1("p1_wait3");
        check("p1_third_addr", bus1.o_mem_addr, 32'h30);
        ack1();
        check("p1_ack_m0", {30'b0, bus1.o_m1_ack, bus1.o_m0_ack}, 32'h1);
        sync();
        bus1.i_mem_ack = 1'b0;
        bus1.i_m0_rd = 1'b0;

        repeat (5) sync();
        check("sb_drain", exp_rdata_q0.size() + exp_rdata_q1.size()
                          + cmd_q0.size() + cmd_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: got no completion expected finish before 400us");
        $fatal(1, "time limit");
    end
endmodule
